// File: rtl/core_pkg.sv
// Shared RV32I core definitions used by the fetch stage and its neighbours.
// Holds the canonical NOP, the default reset PC and the IF/ID register layout.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // ADDI x0,x0,0; doubles as the bubble instruction in the pipeline.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/execute controls, instruction memory bus and IF/ID outputs.
// The fetch stage uses the master view; the surrounding core (or a bench) uses slave.
interface fetch_stage_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 16
);

  logic                     stall_f;
  logic                     stall_d;
  logic                     flush_d;
  logic                     pc_src_e;
  logic [DATA_WIDTH-1:0]    pc_target_e;

  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_rdata;

  logic [DATA_WIDTH-1:0]    instr_d;
  logic [DATA_WIDTH-1:0]    pc_d;
  logic [DATA_WIDTH-1:0]    pc_plus4_d;
  logic                     valid_d;

  modport master (
    input  stall_f,
    input  stall_d,
    input  flush_d,
    input  pc_src_e,
    input  pc_target_e,
    input  imem_rdata,
    output imem_addr,
    output instr_d,
    output pc_d,
    output pc_plus4_d,
    output valid_d
  );

  modport slave (
    output stall_f,
    output stall_d,
    output flush_d,
    output pc_src_e,
    output pc_target_e,
    output imem_rdata,
    input  imem_addr,
    input  instr_d,
    input  pc_d,
    input  pc_plus4_d,
    input  valid_d
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter with async reset and redirect > stall > increment next-state mux.
// The +4 adder wraps silently at the top of the address space.
module pc_reg #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] pc_plus4_f
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] target_aligned;

  assign pc_plus4_f     = pc_q + DATA_WIDTH'(4);
  assign target_aligned = {pc_target_e[DATA_WIDTH-1:2], 2'b00};

  // Redirect beats stall so a resolved branch is never dropped.
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e) begin
      pc_next = target_aligned;
    end else if (stall_f) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_f = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, imem address drive and IF/ID register.
// Flush beats stall on IF/ID; redirect does not imply flush, the hazard unit asserts it.
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [DATA_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0] pc_plus4_f;

  if_id_t if_id_q;
  if_id_t if_id_next;

  pc_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (bus.stall_f),
    .pc_src_e    (bus.pc_src_e),
    .pc_target_e (bus.pc_target_e),
    .pc_f        (pc_f),
    .pc_plus4_f  (pc_plus4_f)
  );

  // Memory ignores the upper PC bits, so PCs differing only above the bus width alias.
  assign bus.imem_addr = pc_f[ADDRESS_WIDTH-1:0];

  always_comb begin
    if_id_next = if_id_q;
    if (bus.flush_d) begin
      if_id_next = IF_ID_BUBBLE;
    end else if (!bus.stall_d) begin
      if_id_next = '{
        instr:    bus.imem_rdata,
        pc:       pc_f,
        pc_plus4: pc_plus4_f,
        valid:    1'b1
      };
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      if_id_q <= if_id_next;
    end
  end

  assign bus.instr_d    = if_id_q.instr;
  assign bus.pc_d       = if_id_q.pc;
  assign bus.pc_plus4_d = if_id_q.pc_plus4;
  assign bus.valid_d    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID
// contents when controls are driven; they are popped and compared after the edge.
module tb_fetch_stage;
  import core_pkg::*;

  logic clk;
  logic rst;

  fetch_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(16)) bus ();

  fetch_stage #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (16),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    if (a == 16'h0000) return 32'h0050_0093;
    if (a == 16'h0004) return 32'h0010_0113;
    return {a, 16'h0513};
  endfunction

  assign bus.imem_rdata = word_at(bus.imem_addr);

  int unsigned n_vec;
  int unsigned n_err;
  if_id_t      exp_q[$];
  logic [31:0] m_pc;
  if_id_t      m_ifid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_0000;
    m_ifid = IF_ID_BUBBLE;
    exp_q.delete();
  endtask

  // One clock with the given controls; model prediction pushed before the edge.
  task automatic step(input logic sf, input logic sd, input logic fl, input logic ps,
                      input logic [31:0] tgt);
    if_id_t e;
    if_id_t g;
    @(negedge clk);
    bus.stall_f     = sf;
    bus.stall_d     = sd;
    bus.flush_d     = fl;
    bus.pc_src_e    = ps;
    bus.pc_target_e = tgt;
    #1;
    check_val("imem_addr", {16'h0, bus.imem_addr}, {16'h0, m_pc[15:0]});
    if (fl) begin
      e = '{instr: 32'h0000_0013, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
    end else if (sd) begin
      e = m_ifid;
    end else begin
      e = '{instr: word_at(m_pc[15:0]), pc: m_pc, pc_plus4: m_pc + 32'd4, valid: 1'b1};
    end
    exp_q.push_back(e);
    m_ifid = e;
    if (ps) m_pc = {tgt[31:2], 2'b00};
    else if (!sf) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check_val("instr_d", bus.instr_d, g.instr);
      check_val("pc_d", bus.pc_d, g.pc);
      check_val("pc_plus4_d", bus.pc_plus4_d, g.pc_plus4);
      check_val("valid_d", {31'h0, bus.valid_d}, {31'h0, g.valid});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_instr"}, bus.instr_d, 32'h0000_0013);
    check_val({tag, "_pc"}, bus.pc_d, 32'h0);
    check_val({tag, "_pc4"}, bus.pc_plus4_d, 32'h0);
    check_val({tag, "_valid"}, {31'h0, bus.valid_d}, 32'h0);
    check_val({tag, "_addr"}, {16'h0, bus.imem_addr}, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.stall_f     = 1'b0;
    bus.stall_d     = 1'b0;
    bus.flush_d     = 1'b0;
    bus.pc_src_e    = 1'b0;
    bus.pc_target_e = 32'h0;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Straight-line fetch from the reset PC.
    step(0, 0, 0, 0, 32'h0);
    check_val("t1_instr", bus.instr_d, 32'h0050_0093);
    step(0, 0, 0, 0, 32'h0);
    check_val("t1_instr2", bus.instr_d, 32'h0010_0113);

    // Full stall at pc_f=8.
    repeat (3) step(1, 1, 0, 0, 32'h0);
    check_val("stall_pc_d", bus.pc_d, 32'h4);
    step(0, 0, 0, 0, 32'h0);
    check_val("unstall_pc8", bus.pc_d, 32'h8);
    step(0, 0, 0, 0, 32'h0);
    check_val("unstall_pc12", bus.pc_d, 32'hC);

    // Redirect with flush at pc_f=0x10.
    step(0, 0, 1, 1, 32'h40);
    check_val("redir_addr", {16'h0, bus.imem_addr}, 32'h40);
    step(0, 0, 0, 0, 32'h0);
    check_val("redir_pc_d", bus.pc_d, 32'h40);

    // Redirect overrides stall_f, low bits cleared.
    step(1, 0, 0, 1, 32'h23);
    check_val("redir_stall_addr", {16'h0, bus.imem_addr}, 32'h20);
    step(0, 0, 0, 0, 32'h0);

    // Flush overrides stall_d; stall_f alone re-fetches the same word.
    step(0, 1, 1, 0, 32'h0);
    check_val("flush_stall_valid", {31'h0, bus.valid_d}, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 32'h0);
    check_val("wrap_pc_d", bus.pc_d, 32'hFFFF_FFFC);
    check_val("wrap_pc4_d", bus.pc_plus4_d, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    check_val("wrap_next_pc_d", bus.pc_d, 32'h0);

    // Aliasing above the address bus width.
    step(0, 0, 0, 1, 32'h0001_0008);
    step(0, 0, 0, 0, 32'h0);
    check_val("alias_instr", bus.instr_d, word_at(16'h0008));

    // Randomised control mix.
    for (int i = 0; i < 40; i++) begin
      step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
           ($urandom % 5) == 0, $urandom);
    end

    // Asynchronous reset mid-cycle during a stall at pc_f=0x80.
    step(0, 0, 1, 1, 32'h80);
    step(1, 1, 0, 0, 32'h0);
    check_val("pre_rst_addr", {16'h0, bus.imem_addr}, 32'h80);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 0, 0, 32'h0);
    check_val("post_rst_pc_d", bus.pc_d, 32'h0);
    check_val("post_rst_instr", bus.instr_d, 32'h0050_0093);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
